// File: rtl/div_control.sv
// rtl/div_control.sv - sequential signed divider with a restoring core and sign fix-up
// Quotient truncates toward zero; remainder takes the dividend's sign.
module div_control #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Finish,
  output logic             Busy,
  output logic             DivByZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FIXUP, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, b_mag, r_reg;
  logic [CW-1:0]    cnt;
  logic             qsign, rsign, ovf_pend;

  logic             accept, div_zero_in, ovf_in;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH:0]   r_shift, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept       = ((state == IDLE) || (state == DONE)) && Start;
  assign div_zero_in  = (Divisor == '0);
  assign ovf_in       = (Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (Divisor == '1);
  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  assign dividend_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign divisor_mag  = Divisor[WIDTH-1]  ? -Divisor  : Divisor;

  // The running remainder is always below the divisor, so it is stored narrow
  // and widened to the full partial-remainder width only for the trial subtract.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign trial   = r_shift - {1'b0, b_mag};
  assign q_fix   = qsign ? -q_reg : q_reg;
  assign r_fix   = rsign ? -r_reg : r_reg;

  always_ff @(posedge clk) begin
    if (Resetn) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (Start) state_next = div_zero_in ? DONE : SHIFT;
      SHIFT:      if (cnt == CW'(WIDTH - 1)) state_next = FIXUP;
      FIXUP:      state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    Finish = (state == DONE);
    Busy   = (state == SHIFT) || (state == FIXUP);
  end

  always_ff @(posedge clk) begin
    if (Resetn) begin
      q_reg     <= '0;
      b_mag     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      ovf_pend  <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else if (accept) begin
      q_reg     <= dividend_mag;
      b_mag     <= divisor_mag;
      r_reg     <= '0;
      cnt       <= '0;
      qsign     <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
      rsign     <= Dividend[WIDTH-1];
      ovf_pend  <= ovf_in;
      Overflow  <= 1'b0;
      DivByZero <= div_zero_in;
      if (div_zero_in) begin
        Quotient  <= '1;
        Remainder <= Dividend;
      end
    end else if (state == SHIFT) begin
      if (!trial[WIDTH]) begin
        r_reg <= trial[WIDTH-1:0];
        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        r_reg <= r_shift[WIDTH-1:0];
        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end else if (state == FIXUP) begin
      Quotient  <= q_fix;
      Remainder <= r_fix;
      Overflow  <= ovf_pend;
    end
  end

endmodule

// File: tb/tb_div_control.sv
// tb/tb_div_control.sv - directed-vector bench for div_control
module tb_div_control;

  logic       clk = 1'b0;
  logic       Resetn, Start, Finish, Busy, DivByZero, Overflow;
  logic [7:0] Dividend, Divisor, Quotient, Remainder;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] last_q = 8'h00;

  div_control #(.WIDTH(8)) dut (
    .clk(clk), .Resetn(Resetn), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Finish(Finish), .Busy(Busy),
    .DivByZero(DivByZero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz, ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_finish(output int lat);
    lat = 0;
    while (!Finish && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, b, eq, er, input logic edz, eov);
    int lat;
    @(negedge clk);
    Dividend = a; Divisor = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Dividend = 8'($urandom); Divisor = 8'($urandom);
    check({name, "_busy"}, int'(Busy), int'(!edz));
    check({name, "_fin0"}, int'(Finish), int'(edz));
    if (!edz) check({name, "_qhold"}, int'(Quotient), int'(last_q));
    wait_finish(lat);
    check({name, "_lat"}, lat, edz ? 0 : 9);
    check({name, "_q"}, int'(Quotient), int'(eq));
    check({name, "_r"}, int'(Remainder), int'(er));
    check({name, "_dz"}, int'(DivByZero), int'(edz));
    check({name, "_ov"}, int'(Overflow), int'(eov));
    last_q = eq;
  endtask

  task automatic check_zero(input string name);
    check({name, "_q"}, int'(Quotient), 0);
    check({name, "_r"}, int'(Remainder), 0);
    check({name, "_fin"}, int'(Finish), 0);
    check({name, "_busy"}, int'(Busy), 0);
    check({name, "_dz"}, int'(DivByZero), 0);
    check({name, "_ov"}, int'(Overflow), 0);
  endtask

  initial begin
    int lat;
    int sa, sb, qi, ri;
    logic [7:0] ra, rb, mq, mr;

    vecs[0]  = '{8'h66, 8'h33, 8'h02, 8'h00, 1'b0, 1'b0};  // 102/51
    vecs[1]  = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};  // -100/7
    vecs[2]  = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};  // 100/-7
    vecs[3]  = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};  // -100/-7
    vecs[4]  = '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};  // 5/0
    vecs[5]  = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};  // -128/-1
    vecs[6]  = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};  // -128/1
    vecs[7]  = '{8'h7F, 8'h0A, 8'h0C, 8'h07, 1'b0, 1'b0};  // 127/10
    vecs[8]  = '{8'h09, 8'h04, 8'h02, 8'h01, 1'b0, 1'b0};  // 9/4
    vecs[9]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};  // 0/5
    vecs[10] = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0};  // -128/0
    vecs[11] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0};  // 127/-128
    vecs[12] = '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0};  // -1/2
    vecs[13] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0};  // -128/-128
    vecs[14] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0};  // -128/127

    Resetn = 1'b1; Start = 1'b0; Dividend = 8'h00; Divisor = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    Resetn = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);

    // Start during SHIFT must be ignored.
    @(negedge clk);
    Dividend = 8'h66; Divisor = 8'h33; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    Dividend = 8'h07; Divisor = 8'h03; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    lat = 4;
    while (!Finish && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_lat", lat, 9);
    check("ignore_q", int'(Quotient), 2);
    check("ignore_r", int'(Remainder), 0);

    // Start held high in DONE restarts back-to-back.
    @(negedge clk);
    Dividend = 8'h7F; Divisor = 8'h0A; Start = 1'b1;
    @(negedge clk);
    check("b2b_fin0", int'(Finish), 0);
    check("b2b_busy", int'(Busy), 1);
    wait_finish(lat);
    Start = 1'b0;
    check("b2b_lat", lat, 9);
    check("b2b_q", int'(Quotient), 12);
    check("b2b_r", int'(Remainder), 7);

    // Reset while SHIFT counter is 3.
    @(negedge clk);
    Dividend = 8'h66; Divisor = 8'h33; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    Resetn = 1'b0;
    last_q = 8'h00;
    run_op("after_rst", 8'h09, 8'h04, 8'h02, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = (i % 10 == 0) ? 8'h00 : 8'($urandom);
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (sb == 0) begin
        mq = 8'hFF; mr = ra;
      end else begin
        qi = sa / sb;
        ri = sa % sb;
        mq = qi[7:0]; mr = ri[7:0];
      end
      run_op($sformatf("rnd_%0d_%0d", sa, sb), ra, rb, mq, mr, sb == 0, (sa == -128) && (sb == -1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
